// File: rtl/tea_pkg.sv
// Shared types and constants for the tea streaming adapter.
package tea_pkg;

    localparam int TEA_NUM_STAGES = 4;

    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } tea_mode_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } adapter_state_t;

endpackage

// File: rtl/tea_result_fifo.sv
// Result FIFO: extra-MSB pointers, the head word is visible on rdata_o whenever not empty.
module tea_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, rptr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/tea_stream_adapter.sv
// Valid/ready wrapper around the stall-free tea pipeline: credit-based issue,
// in-flight tracking shift register, result FIFO, and drain-before-reconfigure FSM.
module tea_stream_adapter
    import tea_pkg::*;
#(
    parameter int NUM_STAGES = TEA_NUM_STAGES,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_mode,
    input  logic [63:0] cfg_key,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        busy,
    output logic [31:0] tea_input_data,
    output logic        tea_mode,
    output logic [63:0] tea_encryption_key,
    input  logic [31:0] tea_output_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    adapter_state_t        state_q, state_d;
    tea_mode_t             cur_mode_q, cur_mode_d;
    logic [63:0]           key_q, key_d;
    logic [NUM_STAGES-1:0] vld_sr_q;
    logic [CW-1:0]         inflight, fifo_count;
    logic                  cfg_match, credit, fire, fifo_full, fifo_empty;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < NUM_STAGES; i++) inflight = inflight + CW'(vld_sr_q[i]);
    end

    // Every accepted word is either in flight or queued, so this sum bounds FIFO occupancy.
    assign credit    = !fifo_full && (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_LIM);
    assign cfg_match = (tea_mode_t'(s_mode) == cur_mode_q) && (cfg_key == key_q);
    assign s_ready   = !rst && (state_q == RUN) && cfg_match && credit;
    assign fire      = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        key_d      = key_q;
        case (state_q)
            RUN:    if (s_valid && !cfg_match) state_d = DRAIN;
            DRAIN: begin
                if (inflight == '0) begin
                    cur_mode_d = tea_mode_t'(s_mode);
                    key_d      = cfg_key;
                    state_d    = SWITCH;
                end
            end
            SWITCH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cur_mode_q <= ENCRYPT;
            key_q      <= '0;
            vld_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            key_q      <= key_d;
            vld_sr_q   <= {vld_sr_q[NUM_STAGES-2:0], fire};
        end
    end

    tea_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (vld_sr_q[NUM_STAGES-1]),
        .wdata_i (tea_output_data),
        .pop_i   (m_valid && m_ready),
        .rdata_o (m_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign m_valid            = !fifo_empty;
    assign busy               = (inflight != '0) || !fifo_empty || (state_q != RUN);
    assign tea_input_data     = s_data;
    assign tea_mode           = cur_mode_q;
    assign tea_encryption_key = key_q;

endmodule

// File: doc/tea_stream_adapter.md
Name: tea_stream_adapter

Overview:
- Streaming front/back-end for the tea pipeline. It accepts 32-bit words over valid/ready and feeds tea_input_data, tea_mode and tea_encryption_key.
- tea has no valid signal and cannot stall. The adapter tracks in-flight words with a shift register, captures tea_output_data into a result FIFO, and presents results downstream over valid/ready.
- Backpressure is handled with credit-based issue.
- Mode or key changes take effect only after the tea pipeline has fully drained.

Parameters:
- NUM_STAGES, 4, tea pipeline depth. Must equal the tea instance's NUM_STAGES.
- FIFO_DEPTH, 8, result FIFO entries. Power of 2, at least NUM_STAGES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  adapter accepts input word
- s_data  in  32  plaintext or ciphertext word
- s_mode  in  1  0 = encrypt, 1 = decrypt; sampled with s_data
- cfg_key  in  64  key; change is detected against the held copy
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  32  result word
- busy  out  1  high when inflight != 0, FIFO not empty, or state != RUN
- tea_input_data  out  32  to tea; combinational = s_data
- tea_mode  out  1  to tea; registered
- tea_encryption_key  out  64  to tea; registered
- tea_output_data  in  32  from tea

Behaviour:
- Reset values:
  - s_ready = 0 while rst is high.
  - m_valid = 0, busy = 0, tea_mode = 0, tea_encryption_key = 0.
  - FSM = RUN, cur_mode = 0, vld_sr = 0, FIFO empty.
  - Reset mid-operation discards in-flight and queued words; no output follows.
- Issue:
  - fire = s_valid & s_ready.
  - vld_sr[NUM_STAGES-1:0] shifts every cycle with vld_sr[0] <= fire.
  - inflight = popcount(vld_sr).
- Capture: when vld_sr[NUM_STAGES-1] is set, tea_output_data is pushed into the FIFO that cycle.
- Latency: a word accepted in cycle t gives m_valid in cycle t+NUM_STAGES+1, i.e. 5 cycles at the default. Back-to-back throughput is 1 word/cycle.
- Credit: s_ready = (state == RUN) & (s_mode == cur_mode) & (cfg_key == key_q) & (fifo_count + inflight < FIFO_DEPTH).
  - The FIFO never overflows.
  - A pop in the same cycle does not grant extra credit; the check is registered-count based.
- FSM states and transitions:
  - RUN: if s_valid & (s_mode != cur_mode | cfg_key != key_q), go to DRAIN. A key change with no s_valid is deferred until the next s_valid.
  - DRAIN: s_ready = 0. When inflight == 0, load tea_mode <= s_mode, cur_mode <= s_mode, key_q/tea_encryption_key <= cfg_key, then go to SWITCH.
  - SWITCH: lasts 1 cycle so tea's internal mode register updates. Then go to RUN.
- Mode and key stability: tea_mode and tea_encryption_key change only when inflight == 0, because tea's mode applies to all stages at once.
- FIFO behaviour:
  - Simultaneous push and pop leaves the count unchanged.
  - Pop on empty cannot occur.
  - m_data is the FIFO head and is held stable while m_valid & !m_ready.
- Pointer arithmetic: pointers are log2(FIFO_DEPTH)+1 bits, wrap modulo, with full/empty derived from the MSB.

Decomposition:
- Package tea_pkg holds:
  - tea_mode_t enum {ENCRYPT = 0, DECRYPT = 1}
  - adapter_state_t enum {RUN, DRAIN, SWITCH}
  - TEA_NUM_STAGES = 4
- Sub-module tea_result_fifo: parameter DEPTH, WIDTH = 32; push/pop/full/empty/count.
- The FSM, vld_sr and credit logic stay in the top module.
- The bench instantiates tea together with the adapter; tea's rst_n is tied to ~rst at the top.

Test Plan:
1. Reset, then single encrypt: s_data 0x01234567, cfg_key 0x0123456789ABCDEF, s_mode 0, accepted cycle 10 → m_valid cycle 15, m_data equal to the golden-model ciphertext; busy drops to 0 in cycle 16.
2. Round trip: feed the step-1 ciphertext with s_mode 1 → DRAIN and SWITCH seen, s_ready low for at least 2 cycles, output 0x01234567.
3. Stream of 20 words with m_ready held 0 → exactly 8 accepted and held in the FIFO, s_ready stays 0. Release m_ready → all 20 emitted in order with no loss or duplication.
4. Alternate modes each word (E, D, E, D) → each mode switch waits for inflight == 0. Every output matches the model for the mode it was accepted under; tea_mode never toggles while vld_sr != 0.
5. Change cfg_key to 0xFFFF0000FFFF0000 while 3 words are in flight, then present s_valid → tea_encryption_key changes only after the last result is captured, and the next word uses the new key.
6. Assert rst with 3 words in flight and 2 in the FIFO → m_valid = 0 immediately, no outputs after reset release, and the first new word behaves as in test 1.
